clk_div_cfg_seq: RTL
====================

// Module: clk_div_cfg_seq
// PURPOSE
//  Wishbone-programmed configuration sequencer for the user-area clock divider.
//  Holds staging registers for two divide ratios and an enable.
//  On a start command it applies them glitch-free: gate outputs, load via req/ack handshake, settle, resume.
//  Sits between the MGMT SoC Wishbone slave port and the divider core; raises user_irq on done/error.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  register window base; decode on adr[31:4]
//  DIV_W       16             width of each divide-ratio field
//  GATE_CYC    4              cycles div_en_o held low before load
//  SETTLE_CYC  8              cycles after ack before div_en_o re-asserts
//  ACK_TMO     64             max cycles waiting for cfg_ack_i before error
// PORTS
//  wb_clk_i    in   1      single clock; all logic on rising edge
//  wb_rst_i    in   1      synchronous, active-high reset
//  wbs_stb_i   in   1      Wishbone strobe
//  wbs_cyc_i   in   1      Wishbone cycle
//  wbs_we_i    in   1      write enable
//  wbs_sel_i   in   4      byte selects
//  wbs_adr_i   in   32     byte address
//  wbs_dat_i   in   32     write data
//  wbs_ack_o   out  1      single-cycle acknowledge
//  wbs_dat_o   out  32     read data, valid with ack
//  div_en_o    out  1      divider run enable
//  div1_o      out  DIV_W  active ratio, output 1
//  div2_o      out  DIV_W  active ratio, output 2
//  cfg_req_o   out  1      load request to divider
//  cfg_ack_i   in   1      divider has latched div1_o/div2_o
//  irq         out  3      [0] done, [1] error, [2] tied 0
// BEHAVIOUR
//  Reset: ack=0, dat_o=0, div_en_o=0, div1_o=div2_o=1, cfg_req_o=0, irq=0, state IDLE.
//  Reset also sets staging DIV1=DIV2=1, CTRL=0, STATUS sticky bits=0. Reset mid-sequence aborts to IDLE.
//  Bus: stb&cyc&decode hit -> ack exactly 1 cycle later, ack is a 1-cycle pulse.
//  Bus: no back-to-back ack; a miss never acks.
//  Bus: writes honour sel per byte; read data registered with ack.
//  Regs (offset): 0x0 CTRL[0]=en [1]=start(W1, self-clears, reads 0) [2]=irq_en.
//  Regs (offset): 0x4 DIV1[DIV_W-1:0]; 0x8 DIV2; 0xC STATUS[2:0]=state [3]=busy [4]=done W1C [5]=err W1C.
//  States: IDLE, RUN, GATE, LOAD, SETTLE.
//  IDLE/RUN + start: if staged DIV1==0 or DIV2==0 -> err=1, no state change. Else snapshot staging -> GATE.
//  GATE: div_en_o=0, count GATE_CYC cycles -> LOAD.
//  LOAD: cfg_req_o=1, div1_o/div2_o = snapshot.
//    cfg_ack_i=1 -> drop req next cycle -> SETTLE.
//    ACK_TMO cycles without ack -> req=0, err=1 -> IDLE, div_en_o=0.
//  SETTLE: count SETTLE_CYC cycles -> RUN if CTRL.en else IDLE; set done=1.
//  RUN: div_en_o follows CTRL.en combinationally-registered (1-cycle latency); clearing en -> IDLE.
//  busy=1 in GATE/LOAD/SETTLE. Start while busy is ignored (no err).
//  DIV writes while busy update staging only; active outputs change only at LOAD entry.
//  irq[0]=done&irq_en, irq[1]=err&irq_en; level, cleared by W1C. W1C and set in same cycle: set wins.
//  Latency: start write ack -> cfg_req_o rises after GATE_CYC+1 cycles.
//  Counters saturate-free: sized $clog2(max+1), reset on state entry.
// STRUCTURE
//  Package clk_div_pkg: register offsets, CTRL/STATUS bit indices, state enum, DIV_W default.
//  Sub-module clk_div_wb_regs: Wishbone decode/ack, staging regs, W1C logic.
//  Top holds the FSM and counters.
// TESTING
//  Reset, read 0xC -> 0x0; div1_o=div2_o=1, div_en_o=0, irq=0.
//  Write DIV1=5, DIV2=12, CTRL=0x7; ack in cfg_ack_i 3 cycles after req -> div1_o=5, div2_o=12.
//    Expect div_en_o=1 after SETTLE_CYC; STATUS.done=1; irq[0]=1.
//  Never assert cfg_ack_i -> after 64 cycles req=0, err=1, irq[1]=1, state IDLE.
//  Write DIV2=0 then start -> err=1, no cfg_req_o, outputs unchanged.
//  Second start and DIV1=9 write during GATE -> single sequence, div1_o keeps first snapshot.
//  Assert wb_rst_i during LOAD -> next cycle all outputs at reset values.
//  Write 0x30 to STATUS -> done/err clear, irq=0.
//  Byte-lane write sel=4'b0001 to DIV1=0xABCD -> reads back low byte only updated.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider configuration sequencer:
// register map, CTRL/STATUS bit positions and the sequencer state encoding.
package clk_div_pkg;

    localparam int DIV_W_DEF = 16;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_DIV1   = 4'h4;
    localparam logic [3:0] OFF_DIV2   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 3;
    localparam int ST_DONE = 4;
    localparam int ST_ERR  = 5;

    // Encoding is software-visible through STATUS[2:0].
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_GATE   = 3'd2,
        S_LOAD   = 3'd3,
        S_SETTLE = 3'd4
    } state_e;

endpackage

// File: rtl/clk_div_cfg_seq_wb_regs.sv
// Wishbone slave for the divider sequencer: address decode, single-cycle ack,
// staging registers, start pulse generation and sticky done/err flags.
module clk_div_wb_regs
    import clk_div_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DIV_W     = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb_i,
    input  logic             cyc_i,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      dat_i,
    output logic             ack_o,
    output logic [31:0]      dat_o,
    input  state_e           state_i,
    input  logic             busy_i,
    input  logic             set_done_i,
    input  logic             set_err_i,
    output logic             ctrl_en_o,
    output logic             irq_en_o,
    output logic             start_o,
    output logic             done_o,
    output logic             err_o,
    output logic [DIV_W-1:0] div1_o,
    output logic [DIV_W-1:0] div2_o
);

    logic             acc;
    logic             wr;
    logic [3:0]       off;
    logic             bus_unused;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [DIV_W-1:0] div1_q, div1_d;
    logic [DIV_W-1:0] div2_q, div2_d;

    function automatic logic [DIV_W-1:0] merge_bytes(input logic [DIV_W-1:0] cur,
                                                     input logic [31:0]      wdat,
                                                     input logic [3:0]       sel);
        logic [DIV_W-1:0] res;
        res = cur;
        for (int b = 0; b < DIV_W; b++) begin
            if (sel[b/8]) res[b] = wdat[b];
        end
        return res;
    endfunction

    // Blocking on ack_q keeps a held strobe from producing back-to-back acks.
    assign acc        = stb_i & cyc_i & (adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    assign wr         = acc & we_i;
    assign off        = {adr_i[3:2], 2'b00};
    assign bus_unused = ^{adr_i[1:0], sel_i, dat_i};

    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        div1_d   = div1_q;
        div2_d   = div2_q;
        start_d  = 1'b0;
        done_d   = done_q;
        err_d    = err_q;
        ack_d    = acc;
        dat_d    = '0;
        if (wr) begin
            case (off)
                OFF_CTRL: begin
                    if (sel_i[0]) begin
                        en_d     = dat_i[CTRL_EN];
                        start_d  = dat_i[CTRL_START];
                        irq_en_d = dat_i[CTRL_IRQ_EN];
                    end
                end
                OFF_DIV1: div1_d = merge_bytes(div1_q, dat_i, sel_i);
                OFF_DIV2: div2_d = merge_bytes(div2_q, dat_i, sel_i);
                OFF_STATUS: begin
                    if (sel_i[0] && dat_i[ST_DONE]) done_d = 1'b0;
                    if (sel_i[0] && dat_i[ST_ERR])  err_d  = 1'b0;
                end
                default: ;
            endcase
        end
        // A hardware set in the same cycle as a W1C must survive.
        if (set_done_i) done_d = 1'b1;
        if (set_err_i)  err_d  = 1'b1;
        if (acc && !we_i) begin
            case (off)
                OFF_CTRL:   dat_d = 32'({irq_en_q, 1'b0, en_q});
                OFF_DIV1:   dat_d = 32'(div1_q);
                OFF_DIV2:   dat_d = 32'(div2_q);
                OFF_STATUS: dat_d = 32'({err_q, done_q, busy_i, state_i});
                default:    dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            div1_q   <= DIV_W'(1);
            div2_q   <= DIV_W'(1);
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
            div1_q   <= div1_d;
            div2_q   <= div2_d;
        end
    end

    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign ctrl_en_o = en_q;
    assign irq_en_o  = irq_en_q;
    assign start_o   = start_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign div1_o    = div1_q;
    assign div2_o    = div2_q;

endmodule

// File: rtl/clk_div_cfg_seq.sv
// Divider configuration sequencer: gates the divider, loads new ratios through
// a req/ack handshake with timeout, waits for settle, then resumes.
module clk_div_cfg_seq
    import clk_div_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DIV_W      = DIV_W_DEF,
    parameter int          GATE_CYC   = 4,
    parameter int          SETTLE_CYC = 8,
    parameter int          ACK_TMO    = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             div_en_o,
    output logic [DIV_W-1:0] div1_o,
    output logic [DIV_W-1:0] div2_o,
    output logic             cfg_req_o,
    input  logic             cfg_ack_i,
    output logic [2:0]       irq
);

    localparam int MAX_GS  = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CNT_MAX = (ACK_TMO > MAX_GS) ? ACK_TMO : MAX_GS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] snap1_q, snap1_d, snap2_q, snap2_d;
    logic [DIV_W-1:0] div1_q, div1_d, div2_q, div2_d;
    logic             div_en_q, div_en_d;
    logic             cfg_req_q, cfg_req_d;
    logic             set_done, set_err, busy;
    logic             ctrl_en, irq_en, start, done, err;
    logic [DIV_W-1:0] stg1, stg2;

    clk_div_wb_regs #(
        .BASE_ADDR (BASE_ADDR),
        .DIV_W     (DIV_W)
    ) u_regs (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .stb_i      (wbs_stb_i),
        .cyc_i      (wbs_cyc_i),
        .we_i       (wbs_we_i),
        .sel_i      (wbs_sel_i),
        .adr_i      (wbs_adr_i),
        .dat_i      (wbs_dat_i),
        .ack_o      (wbs_ack_o),
        .dat_o      (wbs_dat_o),
        .state_i    (state_q),
        .busy_i     (busy),
        .set_done_i (set_done),
        .set_err_i  (set_err),
        .ctrl_en_o  (ctrl_en),
        .irq_en_o   (irq_en),
        .start_o    (start),
        .done_o     (done),
        .err_o      (err),
        .div1_o     (stg1),
        .div2_o     (stg2)
    );

    assign busy = (state_q == S_GATE) || (state_q == S_LOAD) || (state_q == S_SETTLE);

    always_comb begin
        state_d  = state_q;
        snap1_d  = snap1_q;
        snap2_d  = snap2_q;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    if (stg1 == '0 || stg2 == '0) begin
                        set_err = 1'b1;
                    end else begin
                        snap1_d = stg1;
                        snap2_d = stg2;
                        state_d = S_GATE;
                    end
                end else if (state_q == S_RUN && !ctrl_en) begin
                    state_d = S_IDLE;
                end
            end
            S_GATE: begin
                if (cnt_q == CNT_W'(GATE_CYC - 1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (cfg_ack_i) begin
                    state_d = S_SETTLE;
                end else if (cnt_q == CNT_W'(ACK_TMO - 1)) begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d  = ctrl_en ? S_RUN : S_IDLE;
                    set_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter measures time spent in the current timed state only.
        if (state_d != state_q || !busy) cnt_d = '0;
        else                             cnt_d = cnt_q + CNT_W'(1);

        // Outputs are registered from the next state so they never glitch.
        div_en_d  = (state_d == S_RUN);
        cfg_req_d = (state_d == S_LOAD);
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            div1_d = snap1_q;
            div2_d = snap2_q;
        end else begin
            div1_d = div1_q;
            div2_d = div2_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            snap1_q   <= DIV_W'(1);
            snap2_q   <= DIV_W'(1);
            div1_q    <= DIV_W'(1);
            div2_q    <= DIV_W'(1);
            div_en_q  <= 1'b0;
            cfg_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            snap1_q   <= snap1_d;
            snap2_q   <= snap2_d;
            div1_q    <= div1_d;
            div2_q    <= div2_d;
            div_en_q  <= div_en_d;
            cfg_req_q <= cfg_req_d;
        end
    end

    assign div_en_o  = div_en_q;
    assign cfg_req_o = cfg_req_q;
    assign div1_o    = div1_q;
    assign div2_o    = div2_q;
    assign irq       = {1'b0, err & irq_en, done & irq_en};

endmodule
